// File: rtl/ysyx_25020051_exec_ctrl_if.sv
// Instruction-memory fetch handshake between the core sequencer (master) and imem (slave).
// The core holds imem_req/imem_addr steady until imem_rvalid accepts the fetch.
interface ysyx_25020051_exec_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ysyx_25020051_exec_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/HALT sequencer; optional perf counters under YSYX_25020051_PERF_CNT_EN.
// Latency: 3 cycles per instruction with zero-wait imem, +1 per imem wait cycle.
// Backpressure: FETCH holds the request until imem_rvalid, halting after TIMEOUT idle cycles.
module ysyx_25020051_exec_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic                               clk,
    input  logic                               rst,
    ysyx_25020051_exec_ctrl_if.master          imem,
    input  logic                               dec_legal,
    output logic [31:0]                        inst,
    output logic [31:0]                        pc,
    output logic                               rf_wen,
    output logic                               halt,
    output logic [1:0]                         halt_code
`ifdef YSYX_25020051_PERF_CNT_EN
    ,
    output logic [63:0]                        perf_cycles,
    output logic [63:0]                        perf_instret
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_halt;
    logic [1:0]  r_halt_code;
    logic [7:0]  r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_inst      <= '0;
            r_halt      <= 1'b0;
            r_halt_code <= 2'd0;
            r_tmo_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // A response arriving on the last allowed cycle still wins over the timeout.
                    if (imem.imem_rvalid) begin
                        r_inst    <= imem.imem_rdata;
                        r_tmo_cnt <= '0;
                        r_state   <= S_DECODE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_halt      <= 1'b1;
                        r_halt_code <= 2'd2;
                        r_state     <= S_HALT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (r_inst == EBREAK_INST) begin
                        r_halt      <= 1'b1;
                        r_halt_code <= 2'd0;
                        r_state     <= S_HALT;
                    end else if (!dec_legal) begin
                        r_halt      <= 1'b1;
                        r_halt_code <= 2'd1;
                        r_state     <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_pc    <= r_pc + 32'd4;
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Gated by rst so request and write enable are quiet while reset is held.
    assign imem.imem_req  = rst && (r_state == S_FETCH);
    assign imem.imem_addr = r_pc;
    assign rf_wen         = rst && (r_state == S_EXEC);
    assign inst           = r_inst;
    assign pc             = r_pc;
    assign halt           = r_halt;
    assign halt_code      = r_halt_code;

`ifdef YSYX_25020051_PERF_CNT_EN
    logic [63:0] r_perf_cycles;
    logic [63:0] r_perf_instret;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_cycles  <= '0;
            r_perf_instret <= '0;
        end else if (r_state != S_HALT) begin
            r_perf_cycles <= r_perf_cycles + 64'd1;
            if (r_state == S_EXEC) begin
                r_perf_instret <= r_perf_instret + 64'd1;
            end
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_ysyx_25020051_exec_ctrl.sv
// Directed bench for ysyx_25020051_exec_ctrl: reset, zero-wait and wait-state fetch, ebreak,
// illegal opcode, fetch timeout boundary, reset during DECODE, and perf counters when enabled.
module tb_ysyx_25020051_exec_ctrl;

    localparam logic [31:0] ADDI   = 32'h0050_0093;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] RPC    = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        dec_legal;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rf_wen;
    logic        halt;
    logic [1:0]  halt_code;
`ifdef YSYX_25020051_PERF_CNT_EN
    logic [63:0] perf_cycles;
    logic [63:0] perf_instret;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_25020051_exec_ctrl_if u_if ();

    ysyx_25020051_exec_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (u_if),
        .dec_legal (dec_legal),
        .inst      (inst),
        .pc        (pc),
        .rf_wen    (rf_wen),
        .halt      (halt),
        .halt_code (halt_code)
`ifdef YSYX_25020051_PERF_CNT_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_instret (perf_instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in FETCH at RESET_PC, sampled 2 time units after a posedge.
    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;

        rst               = 1'b0;
        dec_legal         = 1'b1;
        u_if.imem_rvalid  = 1'b1;
        u_if.imem_rdata   = ADDI;

        // Reset held with rvalid high
        repeat (3) tick();
        check("rst_req",   64'(u_if.imem_req), 64'd0);
        check("rst_wen",   64'(rf_wen),        64'd0);
        check("rst_pc",    64'(pc),            64'(RPC));
        check("rst_halt",  64'(halt),          64'd0);
        check("rst_inst",  64'(inst),          64'd0);
        check("rst_code",  64'(halt_code),     64'd0);
        rst = 1'b1;
        #1;
        check("rel_req", 64'(u_if.imem_req), 64'd1);

        // Zero-wait: two instructions, 3 cycles each
        for (int i = 0; i < 2; i++) begin
            exp_pc = RPC + 32'(4 * i);
            check("zw_f_req",  64'(u_if.imem_req),  64'd1);
            check("zw_f_addr", 64'(u_if.imem_addr), 64'(exp_pc));
            check("zw_f_wen",  64'(rf_wen),         64'd0);
            tick();
            check("zw_d_inst", 64'(inst),           64'(ADDI));
            check("zw_d_wen",  64'(rf_wen),         64'd0);
            check("zw_d_req",  64'(u_if.imem_req),  64'd0);
            tick();
            check("zw_e_wen",  64'(rf_wen),         64'd1);
            check("zw_e_inst", 64'(inst),           64'(ADDI));
            check("zw_e_pc",   64'(pc),             64'(exp_pc));
            tick();
        end
        check("zw_pc2", 64'(pc), 64'h8000_0008);

        // Two wait cycles: address stable, rf_wen in 5th cycle after FETCH entry
        u_if.imem_rvalid = 1'b0;
        u_if.imem_rdata  = 32'hDEAD_BEEF;
        check("w_addr0", 64'(u_if.imem_addr), 64'h8000_0008);
        tick();
        check("w_addr1", 64'(u_if.imem_addr), 64'h8000_0008);
        check("w_req1",  64'(u_if.imem_req),  64'd1);
        tick();
        check("w_addr2", 64'(u_if.imem_addr), 64'h8000_0008);
        check("w_req2",  64'(u_if.imem_req),  64'd1);
        u_if.imem_rvalid = 1'b1;
        u_if.imem_rdata  = ADDI;
        tick();
        check("w_dec_wen", 64'(rf_wen), 64'd0);
        tick();
        check("w_exec_wen", 64'(rf_wen), 64'd1);
        tick();
        check("w_pc3", 64'(pc), 64'h8000_000C);

        // Counter cleared after the waits: rvalid on the 16th FETCH cycle is accepted
        u_if.imem_rvalid = 1'b0;
        repeat (15) tick();
        check("tb16_halt15", 64'(halt),          64'd0);
        check("tb16_req15",  64'(u_if.imem_req), 64'd1);
        u_if.imem_rvalid = 1'b1;
        tick();
        check("tb16_halt", 64'(halt),          64'd0);
        check("tb16_req",  64'(u_if.imem_req), 64'd0);
        tick();
        check("tb16_wen", 64'(rf_wen), 64'd1);
        tick();

        // Timeout: 16 FETCH cycles with rvalid low
        u_if.imem_rvalid = 1'b0;
        repeat (15) tick();
        check("to_halt15", 64'(halt), 64'd0);
        tick();
        check("to_halt", 64'(halt),          64'd1);
        check("to_code", 64'(halt_code),     64'd2);
        check("to_req",  64'(u_if.imem_req), 64'd0);
        check("to_pc",   64'(pc),            64'h8000_0010);

        // Ebreak at the second instruction
        u_if.imem_rvalid = 1'b1;
        u_if.imem_rdata  = ADDI;
        dec_legal        = 1'b1;
        do_reset();
        check("eb_rst_halt", 64'(halt), 64'd0);
        repeat (3) tick();
        check("eb_pc", 64'(pc), 64'h8000_0004);
        u_if.imem_rdata = EBREAK;
        tick();
        check("eb_d_wen", 64'(rf_wen), 64'd0);
        tick();
        check("eb_halt", 64'(halt),      64'd1);
        check("eb_code", 64'(halt_code), 64'd0);
        check("eb_hpc",  64'(pc),        64'h8000_0004);
        for (int i = 0; i < 20; i++) begin
            u_if.imem_rvalid = 1'($urandom_range(0, 1));
            u_if.imem_rdata  = $urandom;
            tick();
            check("eb_stay_halt", 64'(halt),          64'd1);
            check("eb_stay_wen",  64'(rf_wen),        64'd0);
            check("eb_stay_req",  64'(u_if.imem_req), 64'd0);
            check("eb_stay_pc",   64'(pc),            64'h8000_0004);
            check("eb_stay_inst", 64'(inst),          64'(EBREAK));
        end

        // Illegal opcode
        u_if.imem_rvalid = 1'b1;
        u_if.imem_rdata  = ADDI;
        dec_legal        = 1'b0;
        do_reset();
        tick();
        check("il_d_wen", 64'(rf_wen), 64'd0);
        tick();
        check("il_halt", 64'(halt),      64'd1);
        check("il_code", 64'(halt_code), 64'd1);
        check("il_pc",   64'(pc),        64'(RPC));
        check("il_wen",  64'(rf_wen),    64'd0);

        // Reset asserted during DECODE
        dec_legal = 1'b1;
        do_reset();
        tick();
        check("rd_d_inst", 64'(inst), 64'(ADDI));
        rst = 1'b0;
        #1;
        check("rd_d_wen", 64'(rf_wen), 64'd0);
        tick();
        check("rd_inst", 64'(inst),          64'd0);
        check("rd_pc",   64'(pc),            64'(RPC));
        check("rd_wen",  64'(rf_wen),        64'd0);
        check("rd_req",  64'(u_if.imem_req), 64'd0);
        rst = 1'b1;
        #1;
        check("rd_req_rel", 64'(u_if.imem_req), 64'd1);
        check("rd_wen_rel", 64'(rf_wen),        64'd0);

`ifdef YSYX_25020051_PERF_CNT_EN
        do_reset();
        check("pf_rst_cyc", perf_cycles,  64'd0);
        check("pf_rst_ret", perf_instret, 64'd0);
        repeat (12) tick();
        check("pf_cyc", perf_cycles,  64'd12);
        check("pf_ret", perf_instret, 64'd4);
        check("pf_pc",  64'(pc),      64'h8000_0010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
